// File: rtl/mul_pipe_arbiter.sv
// Round-robin front end that shares one external pipelined 8x8 multiplier among N_REQ requesters.
// Define MUL_ARB_STATS_EN to add the issue_cnt / inflight statistics outputs.
module mul_pipe_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned MUL_LAT = 8,
   parameter int unsigned ID_W    = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 en,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_a,
   input  logic [8*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           mul_a,
   output logic [7:0]           mul_b,
   input  logic [15:0]          mul_product,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [15:0]          rsp_product,
   output logic                 busy
`ifdef MUL_ARB_STATS_EN
   ,
   output logic [15:0]          issue_cnt,
   output logic [3:0]           inflight
`endif
);

   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
   logic [ID_W-1:0]    tag_id_q [MUL_LAT];
   logic [ID_W-1:0]    tag_id_d [MUL_LAT];
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [15:0]        rsp_product_q, rsp_product_d;
   logic               busy_q, busy_d;

   logic               xfer;
   logic [ID_W-1:0]    gnt_id;
   logic [ID_W-1:0]    cand_id;
   int unsigned        cand;

   // Circular search starting at rr_ptr; the first valid requester wins.
   always_comb begin
      xfer    = 1'b0;
      gnt_id  = '0;
      cand    = 0;
      cand_id = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_id = ID_W'(cand);
         if (en && !xfer && req_valid[cand_id]) begin
            xfer   = 1'b1;
            gnt_id = cand_id;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (xfer) begin
         req_ready[gnt_id] = 1'b1;
         mul_a             = req_a[{gnt_id, 3'b000} +: 8];
         mul_b             = req_b[{gnt_id, 3'b000} +: 8];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

      tag_v_d     = {tag_v_q[MUL_LAT-2:0], xfer};
      tag_id_d[0] = gnt_id;
      for (int unsigned s = 1; s < MUL_LAT; s++) tag_id_d[s] = tag_id_q[s-1];

      // The tail stage lines up with the product currently leaving the multiplier.
      rsp_valid_d   = '0;
      rsp_product_d = rsp_product_q;
      if (tag_v_q[MUL_LAT-1]) begin
         rsp_valid_d[tag_id_q[MUL_LAT-1]] = 1'b1;
         rsp_product_d                    = mul_product;
      end

      busy_d = (|tag_v_d) | (|rsp_valid_d);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rr_ptr_q      <= '0;
         tag_v_q       <= '0;
         for (int unsigned s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
         rsp_valid_q   <= '0;
         rsp_product_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         tag_v_q       <= tag_v_d;
         for (int unsigned s = 0; s < MUL_LAT; s++) tag_id_q[s] <= tag_id_d[s];
         rsp_valid_q   <= rsp_valid_d;
         rsp_product_q <= rsp_product_d;
         busy_q        <= busy_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_product = rsp_product_q;
   assign busy        = busy_q;

`ifdef MUL_ARB_STATS_EN
   logic [15:0] issue_cnt_q, issue_cnt_d;
   logic [3:0]  inflight_q, inflight_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      if (xfer && (issue_cnt_q != '1)) issue_cnt_d = issue_cnt_q + 16'd1;
      inflight_d = 4'($countones(tag_v_d));
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         issue_cnt_q <= '0;
         inflight_q  <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         inflight_q  <= inflight_d;
      end
   end

   assign issue_cnt = issue_cnt_q;
   assign inflight  = inflight_q;
`endif

endmodule

// File: tb/tb_mul_pipe_arbiter.sv
// Directed self-checking bench for mul_pipe_arbiter with a behavioural 8-stage multiplier.
// Define MUL_ARB_STATS_EN to also exercise the statistics outputs.
module tb_mul_pipe_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [3:0]  req_ready;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_product;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_product;
   logic        busy;
`ifdef MUL_ARB_STATS_EN
   logic [15:0] issue_cnt;
   logic [3:0]  inflight;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] mp [8];

   always #5 CLK = ~CLK;

   // Multiplier model: product of operands sampled at an edge appears 8 edges later.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 8; i++) mp[i] <= '0;
      end else begin
         mp[0] <= 16'(mul_a) * 16'(mul_b);
         for (int i = 1; i < 8; i++) mp[i] <= mp[i-1];
      end
   end
   assign mul_product = mp[7];

   mul_pipe_arbiter #(.N_REQ(4), .MUL_LAT(8), .ID_W(2)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .en          (en),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .rsp_valid   (rsp_valid),
      .rsp_product (rsp_product),
      .busy        (busy)
`ifdef MUL_ARB_STATS_EN
      ,
      .issue_cnt   (issue_cnt),
      .inflight    (inflight)
`endif
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b0; en = 1'b0; req_valid = '0;
      tick(); tick();
      @(negedge CLK);
      n_checks++;
      if (rsp_valid !== 4'b0000 || rsp_product !== 16'h0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: rsp_valid=%b rsp_product=%h busy=%b, expected 0000/0000/0", rsp_valid, rsp_product, busy);
      end
`ifdef MUL_ARB_STATS_EN
      n_checks++;
      if (issue_cnt !== 16'd0 || inflight !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_stats: issue_cnt=%0d inflight=%0d, expected 0/0", issue_cnt, inflight);
      end
`endif
      en = 1'b1; req_valid = 4'b1010;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_rr_ptr: req_ready=%b, expected 0010", req_ready);
      end
      tick();
      req_valid = '0;
      RST = 1'b1;
      tick();
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_v;
      for (int i = 0; i < 4; i++) begin
         req_a[8*i +: 8] = 8'(i + 1);
         req_b[8*i +: 8] = 8'd10;
      end
      en = 1'b1;
      for (int c = 0; c < 15; c++) begin
         tick();
         req_valid = (c < 5) ? 4'b1111 : 4'b0000;
         @(negedge CLK);
         if (c < 5) begin
            n_checks++;
            if (req_ready !== (4'b0001 << (c % 4)) || mul_a !== 8'((c % 4) + 1)) begin
               n_fail++;
               $display("FAIL rr_grant c=%0d: req_ready=%b mul_a=%0d, expected %b/%0d", c, req_ready, mul_a, 4'b0001 << (c % 4), (c % 4) + 1);
            end
         end
         exp_v = (c >= 9 && c <= 13) ? (4'b0001 << ((c - 9) % 4)) : 4'b0000;
         n_checks++;
         if (rsp_valid !== exp_v) begin
            n_fail++;
            $display("FAIL rr_rsp_valid c=%0d: got %b, expected %b", c, rsp_valid, exp_v);
         end
         if (c >= 9 && c <= 13) begin
            n_checks++;
            if (rsp_product !== 16'((((c - 9) % 4) + 1) * 10)) begin
               n_fail++;
               $display("FAIL rr_rsp_product c=%0d: got %0d, expected %0d", c, rsp_product, (((c - 9) % 4) + 1) * 10);
            end
         end
      end
   endtask

   task automatic test_single;
      logic [3:0] exp_v;
      tick();
      en = 1'b1; req_valid = 4'b0001; req_a[7:0] = 8'd13; req_b[7:0] = 8'd11;
      @(negedge CLK);
      n_checks++;
      if (req_ready !== 4'b0001 || mul_a !== 8'd13 || mul_b !== 8'd11) begin
         n_fail++;
         $display("FAIL single_issue: req_ready=%b mul_a=%0d mul_b=%0d, expected 0001/13/11", req_ready, mul_a, mul_b);
      end
      for (int k = 1; k <= 11; k++) begin
         tick();
         req_valid = '0;
         @(negedge CLK);
         exp_v = (k == 9) ? 4'b0001 : 4'b0000;
         n_checks++;
         if (rsp_valid !== exp_v) begin
            n_fail++;
            $display("FAIL single_rsp_valid k=%0d: got %b, expected %b", k, rsp_valid, exp_v);
         end
         if (k == 9) begin
            n_checks++;
            if (rsp_product !== 16'd143) begin
               n_fail++;
               $display("FAIL single_rsp_product: got %0d, expected 143", rsp_product);
            end
         end
         if (k == 1 || k == 10) begin
            n_checks++;
            if (busy !== (k == 1)) begin
               n_fail++;
               $display("FAIL single_busy k=%0d: got %b, expected %b", k, busy, k == 1);
            end
         end
      end
   endtask

   task automatic test_extremes;
      logic [15:0] exp_p;
      en = 1'b1;
      for (int c = 0; c < 13; c++) begin
         tick();
         req_valid = (c < 3) ? 4'b0001 : 4'b0000;
         case (c)
            0:       begin req_a[7:0] = 8'hFF; req_b[7:0] = 8'hFF; end
            1:       begin req_a[7:0] = 8'h00; req_b[7:0] = 8'hFF; end
            default: begin req_a[7:0] = 8'h80; req_b[7:0] = 8'h02; end
         endcase
         @(negedge CLK);
         if (c < 3) begin
            n_checks++;
            if (req_ready !== 4'b0001) begin
               n_fail++;
               $display("FAIL ext_grant c=%0d: req_ready=%b, expected 0001", c, req_ready);
            end
         end
         if (c >= 9) begin
            case (c)
               9:       exp_p = 16'hFE01;
               10:      exp_p = 16'h0000;
               default: exp_p = 16'h0100;
            endcase
            n_checks++;
            if (rsp_valid !== ((c <= 11) ? 4'b0001 : 4'b0000) || rsp_product !== exp_p) begin
               n_fail++;
               $display("FAIL ext_rsp c=%0d: rsp_valid=%b rsp_product=%h, expected %b/%h", c, rsp_valid, rsp_product, (c <= 11) ? 4'b0001 : 4'b0000, exp_p);
            end
         end
      end
   endtask

   task automatic test_en_gating;
      int n_rsp;
      n_rsp = 0;
      req_a[31:24] = 8'd9; req_b[31:24] = 8'd9;
      req_b[23:16] = 8'd7;
      for (int c = 0; c < 27; c++) begin
         tick();
         if (c < 3) begin
            en = 1'b1; req_valid = 4'b0100; req_a[23:16] = 8'(3 + c);
         end else if (c < 15) begin
            en = 1'b0; req_valid = 4'b1111;
         end else if (c == 15) begin
            en = 1'b1; req_valid = 4'b1111;
         end else begin
            req_valid = 4'b0000;
         end
         @(negedge CLK);
         if (c >= 3 && c < 15) begin
            n_checks++;
            if (req_ready !== 4'b0000 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
               n_fail++;
               $display("FAIL en_block c=%0d: req_ready=%b mul_a=%0d mul_b=%0d, expected 0000/0/0", c, req_ready, mul_a, mul_b);
            end
            if (rsp_valid != 4'b0000) n_rsp++;
         end
         if (c >= 9 && c <= 11) begin
            n_checks++;
            if (rsp_valid !== 4'b0100 || rsp_product !== 16'((3 + c - 9) * 7)) begin
               n_fail++;
               $display("FAIL en_drain c=%0d: rsp_valid=%b rsp_product=%0d, expected 0100/%0d", c, rsp_valid, rsp_product, (3 + c - 9) * 7);
            end
         end
         if (c == 11 || c == 12) begin
            n_checks++;
            if (busy !== (c == 11)) begin
               n_fail++;
               $display("FAIL en_busy c=%0d: got %b, expected %b", c, busy, c == 11);
            end
         end
         if (c == 15) begin
            n_checks++;
            if (req_ready !== 4'b1000 || mul_a !== 8'd9) begin
               n_fail++;
               $display("FAIL en_rise_grant: req_ready=%b mul_a=%0d, expected 1000/9", req_ready, mul_a);
            end
         end
         if (c == 24) begin
            n_checks++;
            if (rsp_valid !== 4'b1000 || rsp_product !== 16'd81) begin
               n_fail++;
               $display("FAIL en_rise_rsp: rsp_valid=%b rsp_product=%0d, expected 1000/81", rsp_valid, rsp_product);
            end
         end
         if (c == 25) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL en_final_busy: got %b, expected 0", busy);
            end
         end
      end
      n_checks++;
      if (n_rsp != 3) begin
         n_fail++;
         $display("FAIL en_rsp_count: got %0d responses, expected 3", n_rsp);
      end
   endtask

   task automatic test_reset_midflight;
      req_a[15:8] = 8'd5; req_b[15:8] = 8'd6;
      en = 1'b1;
      for (int c = 0; c < 28; c++) begin
         tick();
         if (c < 4) req_valid = 4'b0010;
         else if (c == 17) req_valid = 4'b0110;
         else req_valid = 4'b0000;
         if (c == 4) RST = 1'b0;
         if (c == 5) RST = 1'b1;
         @(negedge CLK);
         if (c < 4) begin
            n_checks++;
            if (req_ready !== 4'b0010) begin
               n_fail++;
               $display("FAIL mid_issue c=%0d: req_ready=%b, expected 0010", c, req_ready);
            end
         end
         if (c >= 4 && c <= 16) begin
            n_checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL mid_discard c=%0d: rsp_valid=%b busy=%b, expected 0000/0", c, rsp_valid, busy);
            end
         end
         if (c == 17) begin
            n_checks++;
            if (req_ready !== 4'b0010) begin
               n_fail++;
               $display("FAIL mid_rr_restart: req_ready=%b, expected 0010", req_ready);
            end
         end
         if (c == 26) begin
            n_checks++;
            if (rsp_valid !== 4'b0010 || rsp_product !== 16'd30) begin
               n_fail++;
               $display("FAIL mid_after_rsp: rsp_valid=%b rsp_product=%0d, expected 0010/30", rsp_valid, rsp_product);
            end
         end
      end
   endtask

`ifdef MUL_ARB_STATS_EN
   task automatic test_stats;
      int peak;
      peak = 0;
      RST = 1'b0; req_valid = '0;
      tick();
      RST = 1'b1;
      req_a[7:0] = 8'd1; req_b[7:0] = 8'd1; en = 1'b1;
      for (int c = 0; c < 32; c++) begin
         tick();
         req_valid = (c < 20) ? 4'b0001 : 4'b0000;
         @(negedge CLK);
         if (int'(inflight) > peak) peak = int'(inflight);
         if (c == 8) begin
            n_checks++;
            if (inflight !== 4'd8) begin
               n_fail++;
               $display("FAIL stats_inflight_full: got %0d, expected 8", inflight);
            end
         end
         if (c == 20 || c == 31) begin
            n_checks++;
            if (issue_cnt !== 16'd20) begin
               n_fail++;
               $display("FAIL stats_issue_cnt c=%0d: got %0d, expected 20", c, issue_cnt);
            end
         end
      end
      n_checks++;
      if (peak != 8 || inflight !== 4'd0) begin
         n_fail++;
         $display("FAIL stats_inflight_drain: peak=%0d final=%0d, expected 8/0", peak, inflight);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_extremes();
      test_en_gating();
      test_reset_midflight();
`ifdef MUL_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_pipe_arbiter.md
Name: mul_pipe_arbiter

Overview:
- Shares one 8-stage pipelined 8x8 unsigned multiplier (`multiplication_pipeline`) between N_REQ requesters.
- Accepts at most one operand pair per cycle, chosen by round-robin arbitration.
- Tracks each issued operation through an ID/valid shift register matched to the multiplier latency.
- Routes each 16-bit product back to the requester that issued it as a registered one-cycle response pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 8, multiplier latency in clock edges from operand sample to product valid.
- ID_W, 2, requester ID width; must satisfy ID_W = clog2(N_REQ).

Ports:
- CLK  input  1  clock; rising edge.
- RST  input  1  asynchronous reset, active-low.
- en  input  1  issue enable; low blocks new grants while in-flight operations drain.
- req_valid  input  N_REQ  per-requester operation request.
- req_a  input  8*N_REQ  operand a; requester i uses bits [8i+7:8i].
- req_b  input  8*N_REQ  operand b; same packing as req_a.
- req_ready  output  N_REQ  one-hot grant; combinational.
- mul_a  output  8  operand a to the multiplier; combinational.
- mul_b  output  8  operand b to the multiplier; combinational.
- mul_product  input  16  product from the multiplier.
- rsp_valid  output  N_REQ  one-hot response pulse; registered.
- rsp_product  output  16  product for the pulsed requester; registered.
- busy  output  1  high while any operation is in flight; registered.

Behaviour:
- Reset (RST low, asynchronous):
  - rr_ptr=0, all tag valids=0, rsp_valid=0, rsp_product=16'h0000, busy=0.
  - Products in flight at reset are discarded and produce no rsp_valid.
  - The multiplier shares RST.
- Arbitration:
  - With en=1, grant the first requester with req_valid=1, searching circularly from rr_ptr upward.
  - req_ready is high only for that requester; at most one bit is set.
  - With en=0 or no req_valid, req_ready=0 and mul_a=mul_b=0.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] in the same cycle.
  - mul_a/mul_b carry the granted requester's operands in that cycle.
  - The requester holds its operands until it sees req_ready.
  - rr_ptr <= (granted index + 1) mod N_REQ on a transfer; otherwise unchanged.
  - A continuously requesting requester never waits more than N_REQ-1 transfers.
- Tag pipeline:
  - MUL_LAT stages of {valid, id}.
  - Stage0 <= {transfer, granted id} every edge; stage k <= stage k-1.
  - The tail stage is aligned with mul_product.
- Response:
  - Each edge: rsp_valid <= tail.valid ? onehot(tail.id) : 0, and rsp_product <= mul_product when tail.valid.
  - rsp_product holds its previous value otherwise.
  - Latency: a transfer in cycle t gives rsp_valid in cycle t+MUL_LAT+1 (t+9 at default).
  - Sustained throughput is one response per cycle.
  - No response backpressure: requesters must accept the pulse.
- busy = OR of all tag valids and rsp_valid; registered.
- Boundary conditions:
  - Back-to-back transfers from the same requester are allowed only when it is the sole requester.
  - en falling mid-stream: operations already issued still complete.
  - en rising and a request arriving in the same cycle: grant that cycle.
  - rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro: MUL_ARB_STATS_EN.
- When defined:
  - Adds output issue_cnt[15:0]: counts transfers and saturates at 16'hFFFF.
  - Adds output inflight[3:0]: number of valid tag stages.
  - Both reset to 0 and both update on the same edge as the tag pipeline.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Single request: req 0 with a=8'd13, b=8'd11 at cycle 5 → rsp_valid=4'b0001 and rsp_product=16'd143 at cycle 14 only.
- Round-robin: all four requesters hold req_valid, with a=i+1, b=8'd10 → grants 0,1,2,3,0,…; responses 10,20,30,40 on consecutive cycles, each tagged with its own one-hot ID.
- Extremes: a=b=8'hFF → 16'hFE01; a=8'h00, b=8'hFF → 16'h0000; a=8'h80, b=8'h02 → 16'h0100.
- en gating: issue 3 operations, drop en → req_ready stays 0; exactly 3 responses follow; busy falls the cycle after the last rsp_valid.
- Reset mid-flight: issue 4 operations, pulse RST low at cycle +4 → no rsp_valid afterwards; busy=0; rr_ptr restarts at 0, so the next simultaneous 1 and 2 request grants 1 first.
- With MUL_ARB_STATS_EN: 20 back-to-back transfers → issue_cnt=20; inflight peaks at 8 and returns to 0 after draining.
